descrambler_sync: RTL and testbench
===================================

DESCRAMBLER_SYNC -- requirements
Module: descrambler_sync

Interface
REQ-001 Parameter SYNC_BYTE, default 8'h47: frame sync byte, sent unscrambled at frame position 0.
REQ-002 Parameter FRAME_LEN, default 16: bytes per frame including the sync byte; legal range 2..256.
REQ-003 Parameter LOCK_COUNT, default 3: consecutive good syncs needed to lock; range 1..15.
REQ-004 Parameter MISS_COUNT, default 2: consecutive bad syncs needed to drop lock; range 1..15.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 in_data  input  8  scrambled byte stream from the upstream stage.
REQ-008 in_valid  input  1  in_data is valid.
REQ-009 in_ready  output  1  block accepts in_data this cycle.
REQ-010 out_data  output  8  descrambled payload byte.
REQ-011 out_valid  output  1  out_data is valid.
REQ-012 out_ready  input  1  downstream accepts out_data.
REQ-013 locked  output  1  high while the state machine is in LOCKED.
REQ-014 sync_err_cnt  output  8  saturating count of bad syncs seen while in LOCKED; present only with DESCRAMBLER_STATS_EN.

Function
REQ-015 An input transfer ("accept") occurs when in_valid and in_ready are both high; an output transfer occurs when out_valid and out_ready are both high.
REQ-016 in_ready is driven combinationally as (!out_valid || out_ready).
REQ-017 A payload byte accepted in LOCKED appears on out_data one cycle later, with out_valid high.
REQ-018 out_data and out_valid hold stable while out_valid=1 and out_ready=0.
REQ-019 out_valid clears after an output transfer unless a new payload byte is accepted in the same cycle.
REQ-020 A position counter pos (0..FRAME_LEN-1) advances on each accept and wraps from FRAME_LEN-1 to 0; a byte accepted with pos=0 is the sync position.
REQ-021 The state machine has three states: HUNT, VERIFY and LOCKED; it starts in HUNT.
REQ-022 In HUNT, an accept with in_data==SYNC_BYTE sets pos to 1 and good_cnt to 1, and moves to VERIFY, or directly to LOCKED if LOCK_COUNT==1.
REQ-023 In VERIFY, a sync-position byte equal to SYNC_BYTE increments good_cnt; reaching LOCK_COUNT moves to LOCKED; a mismatch returns to HUNT.
REQ-024 In LOCKED, a sync-position mismatch increments miss_cnt; a match clears miss_cnt; MISS_COUNT consecutive misses return to HUNT.
REQ-025 The sync-position byte is always dropped from the output, whether it matches or not.
REQ-026 In HUNT and VERIFY every accepted byte is consumed and dropped; out_valid never rises in these states.
REQ-027 Keystream: a 7-bit LFSR s with polynomial x^7+x^6+1; per bit, fb=s[6]^s[5] and s={s[5:0],fb}.
REQ-028 Each payload byte advances the LFSR 8 steps; keystream bits are produced MSB first; out_data = in_data ^ keystream.
REQ-029 The LFSR loads 7'h7F on every sync-position accept (match or miss) and on reset; it does not advance on dropped non-sync bytes.
REQ-030 Simultaneous output transfer and accept in the same cycle is a zero-bubble pass; throughput is one byte per cycle.
REQ-031 A transition from LOCKED to HUNT takes effect for the next accept; the byte already in the output register still completes its handshake.

Reset
REQ-032 While rst=1 at a clock edge: state=HUNT, pos=0, good_cnt=0, miss_cnt=0, LFSR=7'h7F, out_valid=0, out_data=8'h00, locked=0, sync_err_cnt=0.
REQ-033 Reset asserted mid-frame or mid-handshake discards the pending output byte; in_ready=1 in the first cycle after reset.

Configuration
REQ-034 With DESCRAMBLER_STATS_EN defined, port sync_err_cnt exists and counts LOCKED-state sync mismatches, saturating at 8'hFF.
REQ-035 Without DESCRAMBLER_STATS_EN, the port and its counter are absent; all other behaviour is identical.

Structure
REQ-036 A shared package descrambler_pkg holds the state enum (HUNT, VERIFY, LOCKED), the LFSR seed 7'h7F, and the polynomial tap constants.
REQ-037 A sub-module lfsr_keystream_8 (7-bit state in, keystream byte and next state out) is purely combinational and instantiated once.

Verification
REQ-038 Reset, then 3 frames with a correct sync -> locked rises on the 3rd sync accept; the first payload byte 8'h02 yields out_data 8'h00.
REQ-039 Hold out_ready=0 for 5 cycles while locked -> out_data/out_valid stable, in_ready=0, no byte lost or duplicated.
REQ-040 While locked, corrupt one sync to 8'h00 -> locked stays 1, sync_err_cnt=1; corrupt 2 consecutive syncs -> locked falls, out_valid stays 0 until relock.
REQ-041 In VERIFY, a wrong byte at the 2nd sync position -> return to HUNT, no output.
REQ-042 Assert rst mid-frame with out_valid=1 -> the next cycle shows out_valid=0, locked=0, in_ready=1.
REQ-043 Random out_ready backpressure over 100 locked frames -> output equals the reference-model payload, byte-exact.

Source files
------------

// File: rtl/descrambler_pkg.sv
// Shared types and constants for the frame-synchronous descrambler.
package descrambler_pkg;

    typedef enum logic [1:0] {
        StHunt,
        StVerify,
        StLocked
    } state_e;

    localparam logic [6:0]  LfsrSeed  = 7'h7F;
    // x^7 + x^6 + 1: feedback from bits 6 and 5 of the left-shifting register.
    localparam int unsigned LfsrTapHi = 6;
    localparam int unsigned LfsrTapLo = 5;

endpackage

// File: rtl/lfsr_keystream_8.sv
// Combinational eight-step advance of the 7-bit keystream LFSR, producing one byte MSB first.
module lfsr_keystream_8
    import descrambler_pkg::*;
(
    input  logic [6:0] state,
    output logic [7:0] keystream,
    output logic [6:0] next_state
);

    logic [6:0] s;
    logic       fb;

    always_comb begin
        s         = state;
        fb        = 1'b0;
        keystream = '0;
        for (int i = 7; i >= 0; i--) begin
            fb           = s[LfsrTapHi] ^ s[LfsrTapLo];
            keystream[i] = fb;
            s            = {s[5:0], fb};
        end
        next_state = s;
    end

endmodule

// File: rtl/descrambler_sync.sv
// Frame-sync hunter and payload descrambler with a one-deep output register.
// Optional sync-error statistics are enabled by defining DESCRAMBLER_STATS_EN.
module descrambler_sync
    import descrambler_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE  = 8'h47,
    parameter int unsigned FRAME_LEN  = 16,
    parameter int unsigned LOCK_COUNT = 3,
    parameter int unsigned MISS_COUNT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       locked
`ifdef DESCRAMBLER_STATS_EN
    ,
    output logic [7:0] sync_err_cnt
`endif
);

    localparam int unsigned    PosW    = $clog2(FRAME_LEN);
    localparam logic [PosW-1:0] PosLast = PosW'(FRAME_LEN - 1);
    localparam logic [3:0]     LockCnt = 4'(LOCK_COUNT);
    localparam logic [3:0]     MissCnt = 4'(MISS_COUNT);

    state_e          state_q;
    logic [PosW-1:0] pos_q;
    logic [3:0]      good_cnt_q;
    logic [3:0]      miss_cnt_q;
    logic [6:0]      lfsr_q;
    logic [7:0]      out_data_q;
    logic            out_valid_q;

    logic [7:0]      ks;
    logic [6:0]      lfsr_next;
    logic            accept;
    logic            out_xfer;
    logic            is_sync;
    logic            sync_pos;
    logic [PosW-1:0] pos_inc;
    logic [3:0]      good_inc;
    logic [3:0]      miss_inc;

    lfsr_keystream_8 u_keystream (
        .state     (lfsr_q),
        .keystream (ks),
        .next_state(lfsr_next)
    );

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_xfer  = out_valid_q && out_ready;
    assign is_sync   = (in_data == SYNC_BYTE);
    assign sync_pos  = (pos_q == '0);
    assign pos_inc   = (pos_q == PosLast) ? '0 : pos_q + PosW'(1);
    assign good_inc  = good_cnt_q + 4'd1;
    assign miss_inc  = miss_cnt_q + 4'd1;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign locked    = (state_q == StLocked);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StHunt;
            pos_q       <= '0;
            good_cnt_q  <= '0;
            miss_cnt_q  <= '0;
            lfsr_q      <= LfsrSeed;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            // A payload accept below overrides this clear, giving a zero-bubble pass.
            if (out_xfer) out_valid_q <= 1'b0;
            if (accept) begin
                unique case (state_q)
                    StHunt: begin
                        if (is_sync) begin
                            pos_q      <= PosW'(1);
                            good_cnt_q <= 4'd1;
                            miss_cnt_q <= '0;
                            lfsr_q     <= LfsrSeed;
                            state_q    <= (LockCnt == 4'd1) ? StLocked : StVerify;
                        end
                    end
                    StVerify: begin
                        if (sync_pos) begin
                            lfsr_q <= LfsrSeed;
                            if (is_sync) begin
                                pos_q      <= pos_inc;
                                good_cnt_q <= good_inc;
                                if (good_inc == LockCnt) begin
                                    state_q    <= StLocked;
                                    miss_cnt_q <= '0;
                                end
                            end else begin
                                state_q    <= StHunt;
                                pos_q      <= '0;
                                good_cnt_q <= '0;
                            end
                        end else begin
                            pos_q <= pos_inc;
                        end
                    end
                    StLocked: begin
                        if (sync_pos) begin
                            lfsr_q <= LfsrSeed;
                            pos_q  <= pos_inc;
                            if (is_sync) begin
                                miss_cnt_q <= '0;
                            end else if (miss_inc == MissCnt) begin
                                state_q    <= StHunt;
                                pos_q      <= '0;
                                good_cnt_q <= '0;
                                miss_cnt_q <= '0;
                            end else begin
                                miss_cnt_q <= miss_inc;
                            end
                        end else begin
                            pos_q       <= pos_inc;
                            lfsr_q      <= lfsr_next;
                            out_data_q  <= in_data ^ ks;
                            out_valid_q <= 1'b1;
                        end
                    end
                    default: state_q <= StHunt;
                endcase
            end
        end
    end

`ifdef DESCRAMBLER_STATS_EN
    logic [7:0] sync_err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_err_cnt_q <= '0;
        end else if (accept && locked && sync_pos && !is_sync && (sync_err_cnt_q != 8'hFF)) begin
            sync_err_cnt_q <= sync_err_cnt_q + 8'd1;
        end
    end

    assign sync_err_cnt = sync_err_cnt_q;
`endif

endmodule

// File: tb/tb_descrambler_sync.sv
// Directed and backpressure bench for descrambler_sync (default parameters).
module tb_descrambler_sync;

    localparam logic [7:0] Sync = 8'h47;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       locked;
`ifdef DESCRAMBLER_STATS_EN
    logic [7:0] sync_err_cnt;
`endif

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    bit         rand_bp = 1'b0;

    descrambler_sync dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .locked   (locked)
`ifdef DESCRAMBLER_STATS_EN
        ,
        .sync_err_cnt(sync_err_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Output transfers happen at the next rising edge; inputs are stable here.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) got_q.push_back(out_data);
    end

    always @(posedge clk) begin
        if (rand_bp) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] ks_next(input logic [6:0] s);
        logic [6:0] t = s;
        logic [7:0] k = '0;
        logic       fb;
        for (int i = 0; i < 8; i++) begin
            fb = t[6] ^ t[5];
            k  = {k[6:0], fb};
            t  = {t[5:0], fb};
        end
        return {t, k};
    endfunction

    // Returns at posedge+1 after the byte has been accepted.
    task automatic send(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input bit track);
        logic [6:0]  s = 7'h7F;
        logic [14:0] r;
        logic [7:0]  b;
        send(Sync);
        for (int i = 0; i < 15; i++) begin
            b = 8'($urandom_range(0, 255));
            if (track) begin
                r = ks_next(s);
                s = r[14:8];
                exp_q.push_back(b ^ r[7:0]);
            end
            send(b);
        end
    endtask

    initial begin
        int bad;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_locked", locked, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", out_data, 0);
`ifdef DESCRAMBLER_STATS_EN
        check("rst_err_cnt", sync_err_cnt, 0);
`endif
        rst = 1'b0;

        // Acquire lock; first locked payload bytes use keystream 02, 0C, 28.
        got_q.delete();
        repeat (2) send_frame(1'b0);
        check("pre_lock_locked", locked, 0);
        check("pre_lock_no_out", got_q.size(), 0);
        send(Sync);
        check("lock_on_3rd_sync", locked, 1);
        send(8'h02);
        check("first_payload_valid", out_valid, 1);
        check("first_payload_data", out_data, 8'h00);
        send(8'hA9);
        check("second_payload_data", out_data, 8'hA5);
        send(8'h28);
        check("third_payload_data", out_data, 8'h00);
        repeat (12) send(8'h00);

        // Hold the output register for five cycles.
        send(Sync);
        got_q.delete();
        send(8'h02);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hA9;
        bad       = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || out_data !== 8'h00 || in_ready !== 1'b0) bad++;
        end
        check("bp_hold_stable", bad, 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_release_valid", out_valid, 1);
        check("bp_release_data", out_data, 8'hA5);
        send(8'h28);
        repeat (12) send(8'h00);
        repeat (2) @(posedge clk);
        #1;
        check("bp_count", got_q.size(), 15);
        check("bp_byte0", got_q[0], 8'h00);
        check("bp_byte1", got_q[1], 8'hA5);
        check("bp_byte2", got_q[2], 8'h00);

        // Sync misses while locked.
        send(8'h00);
        check("one_miss_locked", locked, 1);
`ifdef DESCRAMBLER_STATS_EN
        check("err_cnt_one", sync_err_cnt, 1);
`endif
        repeat (15) send(8'h5A);
        send(Sync);
        repeat (15) send(8'h5A);
        send(8'h00);
        check("miss_after_good_locked", locked, 1);
        repeat (15) send(8'h5A);
        send(8'h00);
        check("two_miss_unlock", locked, 0);
        check("unlock_out_valid", out_valid, 0);
`ifdef DESCRAMBLER_STATS_EN
        check("err_cnt_three", sync_err_cnt, 3);
`endif

        // Failed verify returns to hunt, so three more syncs are needed.
        got_q.delete();
        repeat (5) send(8'h11);
        send(Sync);
        check("verify_not_locked", locked, 0);
        repeat (15) send(8'h11);
        send(8'h00);
        repeat (15) send(8'h11);
        send(Sync);
        repeat (15) send(8'h11);
        send(Sync);
        check("verify_fail_rehunt", locked, 0);
        repeat (15) send(8'h11);
        send(Sync);
        check("relock", locked, 1);
        check("unlocked_no_out", got_q.size(), 0);
        send(8'h02);
        check("relock_first_payload", out_data, 8'h00);

        // Reset with a byte pending in the output register.
        out_ready = 1'b0;
        check("pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_locked", locked, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_data", out_data, 0);
        out_ready = 1'b1;

        // 100 locked frames under random backpressure against the keystream model.
        got_q.delete();
        exp_q.delete();
        repeat (2) send_frame(1'b0);
        rand_bp = 1'b1;
        repeat (100) send_frame(1'b1);
        rand_bp = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rand_count", got_q.size(), exp_q.size());
        bad = 0;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) bad++;
        end
        check("rand_bytes", bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
